// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/load memory read arbiter: requester ownership tags and issue FSM states.
package mem_arb_pkg;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_LOAD  = 1'b1
    } owner_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // Outstanding counter must represent 0..depth inclusive.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order owner/drop tag queue; head is combinational, push/pop take effect next cycle.
// No internal backpressure: caller must not push when full or pop when empty.
module arb_tag_fifo
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push_i,
    input  owner_t push_owner_i,
    input  logic   push_drop_i,
    input  logic   pop_i,
    input  logic   drop_fetch_i,
    output owner_t head_owner_o,
    output logic   head_drop_o,
    output logic   full_o,
    output logic   empty_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] drop_q;
    owner_t           owner_q [DEPTH];

    assign empty_o      = ~vld_q[rd_ptr_q];
    assign full_o       = vld_q[wr_ptr_q];
    assign head_owner_o = owner_q[rd_ptr_q];
    assign head_drop_o  = drop_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
            drop_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                owner_q[i] <= OWN_LOAD;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (drop_fetch_i && vld_q[i] && owner_q[i] == OWN_FETCH) begin
                    drop_q[i] <= 1'b1;
                end
            end
            if (pop_i) begin
                vld_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q        <= rd_ptr_q + PTR_W'(1);
            end
            // Push is applied last so a fresh entry takes its drop bit from the pusher.
            if (push_i) begin
                vld_q[wr_ptr_q]   <= 1'b1;
                owner_q[wr_ptr_q] <= push_owner_i;
                drop_q[wr_ptr_q]  <= push_drop_i;
                wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Arbitrates fetch/load reads onto one in-order memory port; grant to m_arvalid is 1 cycle, responses routed by tag.
// Stalls grants at OUTST_DEPTH outstanding or while m_arvalid waits; ARB_ROUND_ROBIN_EN selects round-robin over load-first.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int OUTST_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_arvalid,
    input  logic [ADDR_W-1:0] f_araddr,
    output logic              f_arready,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              f_rready,
    input  logic              f_flush,
    input  logic              l_arvalid,
    input  logic [ADDR_W-1:0] l_araddr,
    output logic              l_arready,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    input  logic              l_rready,
    output logic              m_arvalid,
    output logic [ADDR_W-1:0] m_araddr,
    input  logic              m_arready,
    input  logic              m_rvalid,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              m_rready
);

    localparam int CNT_W = cnt_width(OUTST_DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] m_araddr_q;
    logic              m_arvalid_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
    owner_t            last_q;
`endif

    logic   can_grant;
    logic   gnt_load;
    logic   gnt_fetch;
    logic   grant;
    logic   pop;
    owner_t head_owner;
    logic   head_drop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   route_load;
    logic   route_fetch;

    // rst_n gates the grant so no arready leaks out while reset is asserted.
    assign can_grant = rst_n && (state_q == IDLE) && !fifo_full
                       && (cnt_q < CNT_W'(OUTST_DEPTH));

    always_comb begin
        gnt_load  = 1'b0;
        gnt_fetch = 1'b0;
        if (can_grant) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (l_arvalid && f_arvalid) begin
                gnt_fetch = (last_q == OWN_LOAD);
                gnt_load  = (last_q == OWN_FETCH);
            end else begin
                gnt_load  = l_arvalid;
                gnt_fetch = f_arvalid;
            end
`else
            gnt_load  = l_arvalid;
            gnt_fetch = f_arvalid && !l_arvalid;
`endif
        end
    end

    assign grant     = gnt_load | gnt_fetch;
    assign l_arready = gnt_load;
    assign f_arready = gnt_fetch;
    assign m_arvalid = m_arvalid_q;
    assign m_araddr  = m_araddr_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            m_arvalid_q <= 1'b0;
            m_araddr_q  <= '0;
            cnt_q       <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q      <= OWN_LOAD;
`endif
        end else begin
            cnt_q <= cnt_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        m_araddr_q  <= gnt_load ? l_araddr : f_araddr;
                        m_arvalid_q <= 1'b1;
                        state_q     <= ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                        last_q      <= gnt_load ? OWN_LOAD : OWN_FETCH;
`endif
                    end
                end
                ISSUE: begin
                    if (m_arready) begin
                        m_arvalid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    m_arvalid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    arb_tag_fifo #(
        .DEPTH (OUTST_DEPTH)
    ) u_tag_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .push_i       (grant),
        .push_owner_i (gnt_load ? OWN_LOAD : OWN_FETCH),
        .push_drop_i  (f_flush && gnt_fetch),
        .pop_i        (pop),
        .drop_fetch_i (f_flush),
        .head_owner_o (head_owner),
        .head_drop_o  (head_drop),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty)
    );

    // Dropped fetch data is sunk here so the memory never stalls on a redirected stream.
    assign route_load  = !fifo_empty && !head_drop && (head_owner == OWN_LOAD);
    assign route_fetch = !fifo_empty && !head_drop && (head_owner == OWN_FETCH);

    always_comb begin
        m_rready = 1'b0;
        if (!fifo_empty) begin
            if (head_drop)        m_rready = 1'b1;
            else if (route_load)  m_rready = l_rready;
            else                  m_rready = f_rready;
        end
    end

    assign pop      = m_rvalid && m_rready;
    assign l_rvalid = route_load && m_rvalid;
    assign f_rvalid = route_fetch && m_rvalid;
    assign l_rdata  = route_load ? m_rdata : '0;
    assign f_rdata  = route_fetch ? m_rdata : '0;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized and directed checks of mem_read_arbiter against a transaction-level queue model.
module tb_mem_read_arbiter;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              f_arvalid, l_arvalid, f_rready, l_rready, f_flush;
    logic [ADDR_W-1:0] f_araddr, l_araddr;
    logic              f_arready, l_arready, f_rvalid, l_rvalid;
    logic [DATA_W-1:0] f_rdata, l_rdata;
    logic              m_arvalid, m_arready, m_rvalid, m_rready;
    logic [ADDR_W-1:0] m_araddr;
    logic [DATA_W-1:0] m_rdata;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .OUTST_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .f_arvalid (f_arvalid),
        .f_araddr  (f_araddr),
        .f_arready (f_arready),
        .f_rvalid  (f_rvalid),
        .f_rdata   (f_rdata),
        .f_rready  (f_rready),
        .f_flush   (f_flush),
        .l_arvalid (l_arvalid),
        .l_araddr  (l_araddr),
        .l_arready (l_arready),
        .l_rvalid  (l_rvalid),
        .l_rdata   (l_rdata),
        .l_rready  (l_rready),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rready  (m_rready)
    );

    typedef struct {
        bit is_load;
        bit drop;
    } ent_t;

    // Reference model: queue of outstanding reads, one pending request slot.
    ent_t        mq[$];
    bit          pend;
    logic [31:0] maddr;
    bit          last_load;

    int n_vec = 0;
    int n_err = 0;
    int n_far, n_lar, n_lrv, n_frv, n_pop;
    logic [31:0] last_frdata;
    logic [31:0] gq[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        pend      = 1'b0;
        maddr     = '0;
        last_load = 1'b1;
    endtask

    task automatic clear_stats();
        n_far = 0; n_lar = 0; n_lrv = 0; n_frv = 0; n_pop = 0;
        last_frdata = '0;
        gq.delete();
    endtask

    task automatic idle_inputs();
        f_arvalid = 0; l_arvalid = 0; f_rready = 0; l_rready = 0; f_flush = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = '0;
    endtask

    // Called at posedge+1 with inputs set; checks mid-cycle, advances the model, returns at next posedge+1.
    task automatic cycle();
        bit ga_l, ga_f, hv, hl, hd, exp_mr, exp_lrv, exp_frv;
        #3;
        ga_l = 0;
        ga_f = 0;
        if (!pend && mq.size() < DEPTH) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (l_arvalid && f_arvalid) begin
                ga_l = !last_load;
                ga_f = last_load;
            end else begin
                ga_l = l_arvalid;
                ga_f = f_arvalid;
            end
`else
            ga_l = l_arvalid;
            ga_f = f_arvalid && !l_arvalid;
`endif
        end
        hv = mq.size() > 0;
        hl = hv && mq[0].is_load;
        hd = hv && mq[0].drop;
        exp_mr  = hv && (hd || (hl ? l_rready : f_rready));
        exp_lrv = hv && !hd && hl && m_rvalid;
        exp_frv = hv && !hd && !hl && m_rvalid;

        chk("l_arready", l_arready, ga_l);
        chk("f_arready", f_arready, ga_f);
        chk("m_arvalid", m_arvalid, pend);
        chk("m_araddr",  m_araddr,  maddr);
        chk("m_rready",  m_rready,  exp_mr);
        chk("l_rvalid",  l_rvalid,  exp_lrv);
        chk("f_rvalid",  f_rvalid,  exp_frv);
        if (exp_lrv) chk("l_rdata", l_rdata, m_rdata);
        if (exp_frv) chk("f_rdata", f_rdata, m_rdata);

        if (f_arready) begin n_far++; gq.push_back(f_araddr); end
        if (l_arready) begin n_lar++; gq.push_back(l_araddr); end
        if (l_rvalid) n_lrv++;
        if (f_rvalid) begin n_frv++; last_frdata = f_rdata; end
        if (m_rvalid && m_rready) n_pop++;

        if (m_rvalid && exp_mr) void'(mq.pop_front());
        if (f_flush) foreach (mq[i]) if (!mq[i].is_load) mq[i].drop = 1'b1;
        if (pend && m_arready) pend = 1'b0;
        if (ga_l || ga_f) begin
            mq.push_back('{ga_l, f_flush && ga_f});
            pend  = 1'b1;
            maddr = ga_l ? l_araddr : f_araddr;
`ifdef ARB_ROUND_ROBIN_EN
            last_load = ga_l;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        idle_inputs();
        m_rvalid = 1; f_rready = 1; l_rready = 1; m_arready = 1;
        for (int i = 0; i < 12; i++) cycle();
        idle_inputs();
        cycle();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_m_arvalid"}, m_arvalid, 0);
        chk({tag, "_m_araddr"},  m_araddr,  0);
        chk({tag, "_f_arready"}, f_arready, 0);
        chk({tag, "_l_arready"}, l_arready, 0);
        chk({tag, "_f_rvalid"},  f_rvalid,  0);
        chk({tag, "_l_rvalid"},  l_rvalid,  0);
        chk({tag, "_m_rready"},  m_rready,  0);
    endtask

    initial begin
        idle_inputs();
        f_araddr = '0;
        l_araddr = '0;
        rst_n    = 0;
        // Drive every input active during reset to prove the outputs are forced low.
        f_arvalid = 1; l_arvalid = 1; m_rvalid = 1; f_rready = 1; l_rready = 1; m_arready = 1;
        repeat (2) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        idle_inputs();
        model_reset();
        rst_n = 1;
        cycle();

        // Single fetch round trip.
        clear_stats();
        f_arvalid = 1; f_araddr = 32'h100; m_arready = 1; f_rready = 1;
        cycle();
        f_arvalid = 0;
        chk("fetch_addr_next_cycle", m_araddr, 32'h100);
        chk("fetch_arvalid_next_cycle", m_arvalid, 1);
        cycle();
        m_rvalid = 1; m_rdata = 32'hDEADBEEF;
        cycle();
        m_rvalid = 0;
        cycle();
        chk("fetch_grants", n_far, 1);
        chk("fetch_rdata", last_frdata, 32'hDEADBEEF);
        chk("fetch_no_load_rvalid", n_lrv, 0);
        drain();

        // Both requesters valid every cycle.
        clear_stats();
        f_arvalid = 1; f_araddr = 32'h200; l_arvalid = 1; l_araddr = 32'h8000;
        m_arready = 1; m_rvalid = 1; f_rready = 1; l_rready = 1;
        for (int i = 0; i < 12; i++) cycle();
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i < gq.size(); i++) chk("rr_alternate", gq[i] != gq[i-1], 1);
`else
        chk("fixed_prio_no_fetch", n_far, 0);
        chk("fixed_prio_loads", n_lar, 6);
`endif
        drain();

        // Outstanding limit.
        clear_stats();
        f_arvalid = 1; f_araddr = 32'h300; m_arready = 1; m_rvalid = 0; f_rready = 1;
        for (int i = 0; i < 12; i++) cycle();
        chk("limit_accepted", n_far, DEPTH);
        m_rvalid = 1; m_rdata = 32'h55;
        cycle();
        m_rvalid = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("limit_after_pop", n_far, DEPTH + 1);
        drain();

        // Flush drops in-flight fetch data.
        clear_stats();
        f_arvalid = 1; f_araddr = 32'h400; m_arready = 1;
        for (int i = 0; i < 6; i++) cycle();
        chk("flush_outstanding", n_far, 3);
        f_arvalid = 0; f_flush = 1;
        cycle();
        f_flush = 0; m_rvalid = 1; m_rdata = 32'hBAD; f_rready = 0;
        for (int i = 0; i < 5; i++) cycle();
        chk("flush_no_frvalid", n_frv, 0);
        chk("flush_pops", n_pop, 3);
        chk("flush_empty_rready", m_rready, 0);
        drain();

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            f_arvalid = $urandom_range(0, 2) != 0;
            l_arvalid = $urandom_range(0, 2) != 0;
            f_araddr  = $urandom;
            l_araddr  = $urandom;
            m_arready = $urandom_range(0, 3) != 0;
            m_rvalid  = $urandom_range(0, 1) != 0;
            m_rdata   = $urandom;
            f_rready  = $urandom_range(0, 3) != 0;
            l_rready  = $urandom_range(0, 3) != 0;
            f_flush   = $urandom_range(0, 15) == 0;
            cycle();
        end
        drain();

        // Reset mid-transaction: two loads outstanding, m_arvalid high.
        clear_stats();
        l_arvalid = 1; l_araddr = 32'h80; m_arready = 1;
        for (int i = 0; i < 3; i++) cycle();
        chk("midrst_pre_arvalid", m_arvalid, 1);
        idle_inputs();
        l_arvalid = 1; m_rvalid = 1; l_rready = 1; f_rready = 1; m_arready = 0;
        #2;
        rst_n = 0;
        #1;
        chk_outputs_zero("midrst");
        repeat (2) @(posedge clk);
        #1;
        idle_inputs();
        model_reset();
        rst_n = 1;
        cycle();
        clear_stats();
        l_arvalid = 1; l_araddr = 32'h40; m_arready = 1; l_rready = 1;
        cycle();
        l_arvalid = 0;
        chk("post_rst_addr", m_araddr, 32'h40);
        cycle();
        m_rvalid = 1; m_rdata = 32'h1234;
        cycle();
        m_rvalid = 0;
        cycle();
        chk("post_rst_load_resp", n_lrv, 1);
        chk("post_rst_pops", n_pop, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, read address width.
REQ-002 SHALL have parameter DATA_W, default 32, read data width.
REQ-003 SHALL have parameter OUTST_DEPTH, default 4, maximum outstanding reads (power of two, >=2).
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports f_arvalid in 1, f_araddr in ADDR_W, f_arready out 1: fetch request channel.
REQ-007 SHALL have ports f_rvalid out 1, f_rdata out DATA_W, f_rready in 1: fetch response channel.
REQ-008 SHALL have port f_flush  input  1  fetch redirect; discard fetch data still in flight.
REQ-009 SHALL have ports l_arvalid in 1, l_araddr in ADDR_W, l_arready out 1: load request channel.
REQ-010 SHALL have ports l_rvalid out 1, l_rdata out DATA_W, l_rready in 1: load response channel.
REQ-011 SHALL have ports m_arvalid out 1, m_araddr out ADDR_W, m_arready in 1: memory request channel.
REQ-012 SHALL have ports m_rvalid in 1, m_rdata in DATA_W, m_rready out 1: memory response channel.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and ISSUE.
REQ-014 In IDLE, with cnt < OUTST_DEPTH and >=1 requester valid, SHALL grant one requester, pulse its arready for that cycle, latch its address into m_araddr, push the owner tag into the owner FIFO, increment cnt and enter ISSUE.
REQ-015 In IDLE, with cnt == OUTST_DEPTH, SHALL hold both arready low and remain in IDLE.
REQ-016 In ISSUE, m_arvalid SHALL be 1 and m_araddr stable until m_arready; on m_arready SHALL return to IDLE.
REQ-017 Grant-to-m_arvalid latency SHALL be exactly 1 cycle; at most one arready is high in any cycle.
REQ-018 Memory responses are in order; the FIFO head tag SHALL select the response destination.
REQ-019 Head tag load: l_rvalid = m_rvalid, l_rdata = m_rdata, m_rready = l_rready; the fetch channel SHALL stay idle.
REQ-020 Head tag fetch without drop: routing SHALL be the same as REQ-019, but on the fetch channel.
REQ-021 Head tag with drop bit set: m_rready SHALL be 1 and neither rvalid is asserted (response discarded).
REQ-022 On each m_rvalid & m_rready handshake, SHALL pop the FIFO and decrement cnt.
REQ-023 cnt SHALL hold when a capture and a pop occur in the same cycle; the FIFO pointers SHALL wrap modulo OUTST_DEPTH.
REQ-024 With the FIFO empty, m_rready SHALL be 0.
REQ-025 On f_flush, SHALL set the drop bit in every valid FIFO entry tagged fetch, including the entry being pushed in that cycle and the one currently in ISSUE.
REQ-026 f_flush SHALL NOT withdraw m_arvalid, SHALL NOT affect load entries, and SHALL NOT block a fetch grant in the same cycle.

Reset
REQ-027 While rst_n is low, SHALL force: state=IDLE, cnt=0, FIFO pointers 0, drop bits 0, last-grant=load, m_araddr=0.
REQ-028 While rst_n is low, SHALL drive m_arvalid, f_arready, l_arready, f_rvalid, l_rvalid and m_rready to 0.
REQ-029 Reset mid-transaction SHALL discard all outstanding tags without further handshakes.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined, when both requesters are valid SHALL grant the one not granted last, then update last-grant.
REQ-031 Without ARB_ROUND_ROBIN_EN, SHALL use fixed priority: load over fetch; last-grant register is not built.

Structure
REQ-032 Shared package mem_arb_pkg SHALL hold owner_t enum (OWN_FETCH, OWN_LOAD) and state_t enum (IDLE, ISSUE).
REQ-033 The owner/drop queue SHALL be sub-module arb_tag_fifo: parameterised depth, push, pop, full/empty, bulk drop-mark input.

Verification
REQ-034 Fetch only, f_araddr=0x100, m_arready=1, response 0xDEADBEEF -> f_arready high 1 cycle, m_araddr=0x100 next cycle, f_rdata=0xDEADBEEF, l_rvalid never high.
REQ-035 Both valid every cycle, fetch 0x200, load 0x8000, with RR -> m_araddr alternates 0x8000, 0x200, 0x8000.
REQ-036 Same stimulus without RR -> fetch never granted while l_arvalid high.
REQ-037 m_rvalid held 0, issue 5 fetches -> 4 accepted, 5th f_arready low until the first response handshakes.
REQ-038 3 fetches outstanding, then f_flush, then 3 responses -> no f_rvalid, m_rready=1, cnt returns to 0.
REQ-039 Deassert rst_n with 2 outstanding and m_arvalid high -> all outputs 0 within the cycle; after release, a new load 0x40 completes normally.
